game_ctrl: RTL and testbench
============================

Name: game_ctrl

Overview:
- Top-level game sequencer that drives the `state` and score inputs of the UI text overlay generator.
- Tracks game phase (MENU/PLAYING/DEAD/WIN), keeps a 3-digit BCD score and a level counter, and issues one-cycle sound triggers.
- Sits between the input/collision logic (upstream) and the UI overlay and sound blocks (downstream).

Parameters:
- DEAD_HOLD_FRAMES, 120, frame_ticks spent in DEAD before the automatic return to MENU (1..255).
- WIN_HOLD_FRAMES, 120, frame_ticks spent in WIN before advancing to the next level (1..255).
- HOME_POINTS, 10, score added on frog_home (0..99, unsigned).
- LEVEL_MAX, 15, saturating upper bound of the level counter (1..15).

Ports:
- clk  in  1  system clock (pixel clock domain).
- rst_n  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame (end of active area).
- any_key  in  1  one-cycle pulse, debounced key press.
- frog_advance  in  1  one-cycle pulse; frog reached a new furthest row.
- frog_hit  in  1  one-cycle pulse; collision or drowning.
- frog_home  in  1  one-cycle pulse; frog reached the goal row.
- state  out  2  0=MENU, 1=PLAYING, 2=DEAD, 3=WIN.
- score_bcd  out  12  [11:8] hundreds, [7:4] tens, [3:0] ones.
- level  out  4  current level, binary, starts at 1.
- sound_trig  out  1  one-cycle pulse requesting a sound.
- sound_id  out  2  0=UI_PRESS, 1=NEXTLEVEL, 2=CRASH, 3=CELEBRATION; valid while sound_trig=1, holds its last value otherwise.

Behaviour:
- All outputs are registered. An input sampled high at edge N produces its effect on outputs after edge N (visible in cycle N+1).
- Reset (async assert, sync release): state=MENU, score_bcd=0x000, level=1, sound_trig=0, sound_id=0, hold counter=0.
- MENU:
  - any_key -> PLAYING; score_bcd=0x000; level=1; sound_trig=1, sound_id=0.
  - The previous score stays displayed until that key press.
  - frog_* inputs are ignored.
- PLAYING, per-cycle priority frog_hit > frog_home > frog_advance (only the winning event takes effect):
  - frog_hit -> DEAD; sound_id=2; score unchanged.
  - frog_home -> WIN; score += HOME_POINTS; sound_id=3.
  - frog_advance -> score += 1; state unchanged; no sound.
  - any_key is ignored.
- DEAD:
  - Hold counter cleared on entry and incremented on each frame_tick.
  - On the DEAD_HOLD_FRAMES-th frame_tick -> MENU, with no sound.
  - any_key and frog_* are ignored.
- WIN:
  - Same hold mechanism using WIN_HOLD_FRAMES.
  - On expiry -> PLAYING; level = min(level+1, LEVEL_MAX); sound_id=1. Score is retained.
  - frog_* and any_key are ignored.
- A frame_tick in the same cycle as the DEAD/WIN entry event does not count toward the hold.
- Score arithmetic:
  - Digit-wise BCD add with decimal carry.
  - If the true sum exceeds 999, score_bcd saturates at 0x999.
  - Each digit is always in 0..9; no invalid BCD values are ever produced.
- sound_trig is high for exactly one cycle per transition or event listed above. It never stays high two consecutive cycles unless two qualifying events occur on consecutive edges.
- Undefined state encodings are impossible: all four 2-bit codes are valid states.
- Reset asserted mid-hold or mid-game returns to the reset values immediately (asynchronously).

Test Plan:
- Reset, then any_key pulse -> cycle after: state=1, score_bcd=0x000, level=1, sound_trig=1 for 1 cycle with sound_id=0.
- In PLAYING: 9 frog_advance pulses then 1 more -> score_bcd goes 0x009 then 0x010. Then frog_home -> 0x020, state=3, sound_id=3.
- DEAD_HOLD_FRAMES=3: frog_hit and frog_home in the same cycle -> state=2, score unchanged, sound_id=2. After the 3rd frame_tick -> state=0, sound_trig stays 0.
- WIN_HOLD_FRAMES=2, LEVEL_MAX=2, level=2: two frame_ticks -> state=1, level stays 2, sound_id=1. Ticks 1 and 0 alone change nothing.
- Preload score 0x995 via advances, then frog_home -> score_bcd=0x999. A further frog_advance keeps 0x999.
- Assert rst_n=0 in WIN mid-hold -> state=0, score=0x000, level=1, sound_trig=0 without waiting for a clk edge.

Source files
------------

// File: rtl/game_ctrl.sv
// Game sequencer: tracks the MENU/PLAYING/DEAD/WIN phase, a saturating 3-digit BCD score and the level.
// It also issues one-cycle sound triggers. All outputs come straight from flops.
module game_ctrl #(
  parameter int DEAD_HOLD_FRAMES = 120,
  parameter int WIN_HOLD_FRAMES  = 120,
  parameter int HOME_POINTS      = 10,
  parameter int LEVEL_MAX        = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        any_key,
  input  logic        frog_advance,
  input  logic        frog_hit,
  input  logic        frog_home,
  output logic [1:0]  state,
  output logic [11:0] score_bcd,
  output logic [3:0]  level,
  output logic        sound_trig,
  output logic [1:0]  sound_id
);

  typedef enum logic [1:0] {
    ST_MENU    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DEAD    = 2'd2,
    ST_WIN     = 2'd3
  } state_t;

  localparam logic [1:0] SND_UI    = 2'd0;
  localparam logic [1:0] SND_NEXT  = 2'd1;
  localparam logic [1:0] SND_CRASH = 2'd2;
  localparam logic [1:0] SND_CELEB = 2'd3;

  // Hold counters compare against the last count value, so the N-th tick exits.
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_HOLD_FRAMES - 1);
  localparam logic [7:0] WIN_LAST  = 8'(WIN_HOLD_FRAMES - 1);
  localparam logic [3:0] HOME_TENS = 4'(HOME_POINTS / 10);
  localparam logic [3:0] HOME_ONES = 4'(HOME_POINTS % 10);
  localparam logic [3:0] LVL_MAX   = 4'(LEVEL_MAX);

  state_t      state_q, state_d;
  logic [11:0] score_q, score_d;
  logic [3:0]  level_q, level_d;
  logic        sound_trig_q, sound_trig_d;
  logic [1:0]  sound_id_q, sound_id_d;
  logic [7:0]  hold_q, hold_d;

  // Digit-wise decimal add; a carry out of the hundreds digit saturates at 999.
  function automatic logic [11:0] bcd_add(input logic [11:0] s,
                                          input logic [3:0]  add_tens,
                                          input logic [3:0]  add_ones);
    logic [4:0] ones, tens, hund;
    logic       c0, c1;
    ones = {1'b0, s[3:0]} + {1'b0, add_ones};
    c0   = (ones > 5'd9);
    if (c0) ones = ones - 5'd10;
    tens = {1'b0, s[7:4]} + {1'b0, add_tens} + {4'd0, c0};
    c1   = (tens > 5'd9);
    if (c1) tens = tens - 5'd10;
    hund = {1'b0, s[11:8]} + {4'd0, c1};
    if (hund > 5'd9) return 12'h999;
    return {hund[3:0], tens[3:0], ones[3:0]};
  endfunction

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    level_d      = level_q;
    sound_trig_d = 1'b0;
    sound_id_d   = sound_id_q;
    hold_d       = hold_q;
    case (state_q)
      ST_MENU: begin
        if (any_key) begin
          state_d      = ST_PLAYING;
          score_d      = 12'h000;
          level_d      = 4'd1;
          sound_trig_d = 1'b1;
          sound_id_d   = SND_UI;
        end
      end
      ST_PLAYING: begin
        if (frog_hit) begin
          state_d      = ST_DEAD;
          hold_d       = 8'd0;
          sound_trig_d = 1'b1;
          sound_id_d   = SND_CRASH;
        end else if (frog_home) begin
          state_d      = ST_WIN;
          hold_d       = 8'd0;
          score_d      = bcd_add(score_q, HOME_TENS, HOME_ONES);
          sound_trig_d = 1'b1;
          sound_id_d   = SND_CELEB;
        end else if (frog_advance) begin
          score_d = bcd_add(score_q, 4'd0, 4'd1);
        end
      end
      ST_DEAD: begin
        if (frame_tick) begin
          if (hold_q == DEAD_LAST) state_d = ST_MENU;
          else                     hold_d  = hold_q + 8'd1;
        end
      end
      ST_WIN: begin
        if (frame_tick) begin
          if (hold_q == WIN_LAST) begin
            state_d      = ST_PLAYING;
            level_d      = (level_q < LVL_MAX) ? level_q + 4'd1 : LVL_MAX;
            sound_trig_d = 1'b1;
            sound_id_d   = SND_NEXT;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_MENU;
      score_q      <= 12'h000;
      level_q      <= 4'd1;
      sound_trig_q <= 1'b0;
      sound_id_q   <= SND_UI;
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      score_q      <= score_d;
      level_q      <= level_d;
      sound_trig_q <= sound_trig_d;
      sound_id_q   <= sound_id_d;
      hold_q       <= hold_d;
    end
  end

  assign state      = state_q;
  assign score_bcd  = score_q;
  assign level      = level_q;
  assign sound_trig = sound_trig_q;
  assign sound_id   = sound_id_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed table-driven bench for game_ctrl with short holds and a low level cap.
// Each vector drives inputs for one clock and checks the registered outputs just after that edge.
module tb_game_ctrl;

  logic        clk;
  logic        rst_n;
  logic        frame_tick, any_key, frog_advance, frog_hit, frog_home;
  logic [1:0]  state;
  logic [11:0] score_bcd;
  logic [3:0]  level;
  logic        sound_trig;
  logic [1:0]  sound_id;

  int testsRun = 0;
  int testsFailed = 0;

  // Input bundle order: {frame_tick, any_key, frog_advance, frog_hit, frog_home}
  localparam logic [4:0] N = 5'b00000;
  localparam logic [4:0] T = 5'b10000;
  localparam logic [4:0] K = 5'b01000;
  localparam logic [4:0] A = 5'b00100;
  localparam logic [4:0] H = 5'b00010;
  localparam logic [4:0] M = 5'b00001;

  typedef struct {
    string       name;
    logic [4:0]  in;
    logic [1:0]  expState;
    logic [11:0] expScore;
    logic [3:0]  expLevel;
    logic        expTrig;
    logic [1:0]  expId;
  } vec_t;

  vec_t vecs[$];

  game_ctrl #(
    .DEAD_HOLD_FRAMES(3),
    .WIN_HOLD_FRAMES (2),
    .HOME_POINTS     (10),
    .LEVEL_MAX       (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .any_key     (any_key),
    .frog_advance(frog_advance),
    .frog_hit    (frog_hit),
    .frog_home   (frog_home),
    .state       (state),
    .score_bcd   (score_bcd),
    .level       (level),
    .sound_trig  (sound_trig),
    .sound_id    (sound_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] toBcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic void addVec(input string nm, input logic [4:0] in,
                                 input logic [1:0] st, input logic [11:0] sc,
                                 input logic [3:0] lv, input logic tr,
                                 input logic [1:0] id);
    vec_t v;
    v.name = nm; v.in = in; v.expState = st; v.expScore = sc;
    v.expLevel = lv; v.expTrig = tr; v.expId = id;
    vecs.push_back(v);
  endfunction

  // Drive one cycle of inputs, let the edge sample them, then release.
  task automatic applyStimulus(input logic [4:0] in);
    {frame_tick, any_key, frog_advance, frog_hit, frog_home} = in;
    @(posedge clk);
    #1;
    {frame_tick, any_key, frog_advance, frog_hit, frog_home} = N;
  endtask

  task automatic checkOutput(input string nm, input logic [1:0] st,
                             input logic [11:0] sc, input logic [3:0] lv,
                             input logic tr, input logic [1:0] id);
    testsRun++;
    if (state !== st || score_bcd !== sc || level !== lv ||
        sound_trig !== tr || sound_id !== id) begin
      testsFailed++;
      $display("[TB] FAIL %s: got state=%0d score=%h level=%0d trig=%b id=%0d, expected state=%0d score=%h level=%0d trig=%b id=%0d",
               nm, state, score_bcd, level, sound_trig, sound_id, st, sc, lv, tr, id);
    end
  endtask

  initial begin
    {frame_tick, any_key, frog_advance, frog_hit, frog_home} = N;
    rst_n = 1'b0;

    // Start a game and count up through a decimal carry.
    addVec("start_key",   K, 2'd1, 12'h000, 4'd1, 1'b1, 2'd0);
    addVec("start_idle",  N, 2'd1, 12'h000, 4'd1, 1'b0, 2'd0);
    for (int i = 1; i <= 9; i++)
      addVec("adv_to_9",  A, 2'd1, toBcd(i), 4'd1, 1'b0, 2'd0);
    addVec("adv_carry",   A, 2'd1, 12'h010, 4'd1, 1'b0, 2'd0);
    // Tick on the entry cycle must not count toward the win hold.
    addVec("home_tick",   M | T, 2'd3, 12'h020, 4'd1, 1'b1, 2'd3);
    addVec("win_tick1",   T, 2'd3, 12'h020, 4'd1, 1'b0, 2'd3);
    addVec("win_idle",    N, 2'd3, 12'h020, 4'd1, 1'b0, 2'd3);
    addVec("win_tick2",   T, 2'd1, 12'h020, 4'd2, 1'b1, 2'd1);
    // Hit beats home in the same cycle.
    addVec("hit_home",    H | M, 2'd2, 12'h020, 4'd2, 1'b1, 2'd2);
    addVec("dead_tick1",  T, 2'd2, 12'h020, 4'd2, 1'b0, 2'd2);
    addVec("dead_tick2",  T, 2'd2, 12'h020, 4'd2, 1'b0, 2'd2);
    addVec("dead_key",    K, 2'd2, 12'h020, 4'd2, 1'b0, 2'd2);
    addVec("dead_tick3",  T, 2'd0, 12'h020, 4'd2, 1'b0, 2'd2);
    addVec("menu_adv",    A, 2'd0, 12'h020, 4'd2, 1'b0, 2'd2);
    addVec("menu_hit",    H, 2'd0, 12'h020, 4'd2, 1'b0, 2'd2);
    addVec("restart",     K, 2'd1, 12'h000, 4'd1, 1'b1, 2'd0);
    // Two wins: the second must saturate the level at 2.
    addVec("home_l1",     M, 2'd3, 12'h010, 4'd1, 1'b1, 2'd3);
    addVec("w1_tick1",    T, 2'd3, 12'h010, 4'd1, 1'b0, 2'd3);
    addVec("w1_tick2",    T, 2'd1, 12'h010, 4'd2, 1'b1, 2'd1);
    addVec("home_l2",     M, 2'd3, 12'h020, 4'd2, 1'b1, 2'd3);
    addVec("w2_tick1",    T, 2'd3, 12'h020, 4'd2, 1'b0, 2'd3);
    addVec("w2_idle",     N, 2'd3, 12'h020, 4'd2, 1'b0, 2'd3);
    addVec("w2_tick2",    T, 2'd1, 12'h020, 4'd2, 1'b1, 2'd1);
    addVec("play_key",    K, 2'd1, 12'h020, 4'd2, 1'b0, 2'd1);
    for (int i = 21; i <= 995; i++)
      addVec("adv_run",   A, 2'd1, toBcd(i), 4'd2, 1'b0, 2'd1);
    addVec("home_sat",    M, 2'd3, 12'h999, 4'd2, 1'b1, 2'd3);
    addVec("ws_tick1",    T, 2'd3, 12'h999, 4'd2, 1'b0, 2'd3);
    addVec("ws_tick2",    T, 2'd1, 12'h999, 4'd2, 1'b1, 2'd1);
    addVec("adv_sat",     A, 2'd1, 12'h999, 4'd2, 1'b0, 2'd1);
    addVec("home_sat2",   M, 2'd3, 12'h999, 4'd2, 1'b1, 2'd3);
    addVec("mid_hold",    T, 2'd3, 12'h999, 4'd2, 1'b0, 2'd3);

    #12;
    checkOutput("reset_state", 2'd0, 12'h000, 4'd1, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].in);
      checkOutput(vecs[i].name, vecs[i].expState, vecs[i].expScore,
                  vecs[i].expLevel, vecs[i].expTrig, vecs[i].expId);
    end

    // Asynchronous reset in the middle of a win hold, checked before any edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset", 2'd0, 12'h000, 4'd1, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back qualifying events keep sound_trig high on consecutive cycles.
    applyStimulus(K);
    checkOutput("b2b_key", 2'd1, 12'h000, 4'd1, 1'b1, 2'd0);
    applyStimulus(H);
    checkOutput("b2b_hit", 2'd2, 12'h000, 4'd1, 1'b1, 2'd2);
    applyStimulus(T);
    applyStimulus(T);
    checkOutput("b2b_hold", 2'd2, 12'h000, 4'd1, 1'b0, 2'd2);
    applyStimulus(T);
    checkOutput("b2b_menu", 2'd0, 12'h000, 4'd1, 1'b0, 2'd2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
